// File: rtl/uartrx_pkg.sv
// Shared UART RX definitions: parity mode encodings and the frame checker state set.
package uartrx_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } rx_state_e;

endpackage

// File: rtl/uartrx_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module uartrx_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uartrx_frame_chk.sv
// UART RX frame checker: collects data bits after a validated start bit, checks
// optional parity and 1-2 stop bits, and reports the word with per-frame error flags.
//
//   state     | meaning
//   ----------+----------------------------------------------
//   ST_IDLE   | waiting for frame_start
//   ST_DATA   | shifting in DATA_BITS data samples, LSB first
//   ST_PARITY | one parity sample (odd/even modes only)
//   ST_STOP   | STOP_BITS stop samples, any 0 is a framing error
//   ST_DONE   | one cycle, outputs valid, frame_done high
module uartrx_frame_chk
  import uartrx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 frame_start,
  input  logic                 bit_strobe,
  input  logic                 rx_bit,
  input  logic [1:0]           parity_mode,
  input  logic                 fc_clear,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_done,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  rx_state_e state, next_state;

  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_acc;
  logic [1:0]           mode_q;
  logic                 par_pend;
  logic                 frm_pend;

  logic enter_done;
  logic frm_final;
  logic par_bad;
  logic err_inc;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    enter_done = 1'b0;
    case (state)
      ST_IDLE:   if (frame_start) next_state = ST_DATA;
      ST_DATA: begin
        if (bit_strobe && (bit_cnt == LAST_DATA))
          next_state = (mode_q == PAR_NONE) ? ST_STOP : ST_PARITY;
      end
      ST_PARITY: if (bit_strobe) next_state = ST_STOP;
      ST_STOP: begin
        if (bit_strobe && (stop_cnt == LAST_STOP)) begin
          next_state = ST_DONE;
          enter_done = 1'b1;
        end
      end
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // The last stop sample must be folded in here, since it lands on the same edge as the load.
  assign frm_final = frm_pend | ~rx_bit;
  assign par_bad   = (mode_q == PAR_EVEN) ? (par_acc ^ rx_bit) : ~(par_acc ^ rx_bit);
  assign err_inc   = enter_done & (par_pend | frm_final);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shift_reg <= '0;
      par_acc   <= 1'b0;
      mode_q    <= PAR_NONE;
      par_pend  <= 1'b0;
      frm_pend  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_acc  <= 1'b0;
            par_pend <= 1'b0;
            frm_pend <= 1'b0;
            mode_q   <= ((parity_mode == PAR_ODD) || (parity_mode == PAR_EVEN))
                        ? parity_mode : PAR_NONE;
          end
        end
        ST_DATA: begin
          if (bit_strobe) begin
            shift_reg <= {rx_bit, shift_reg[DATA_BITS-1:1]};
            par_acc   <= par_acc ^ rx_bit;
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
        ST_PARITY: if (bit_strobe) par_pend <= par_bad;
        ST_STOP: begin
          if (bit_strobe) begin
            stop_cnt <= stop_cnt + 1'b1;
            if (!rx_bit) frm_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '0;
      frame_done    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      frame_done <= enter_done;
      if (enter_done) rx_data <= shift_reg;
      if (fc_clear) begin
        parity_error  <= 1'b0;
        framing_error <= 1'b0;
      end else if (enter_done) begin
        parity_error  <= par_pend;
        framing_error <= frm_final;
      end
    end
  end

  uartrx_sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (fc_clear),
    .inc   (err_inc),
    .count (err_count)
  );

endmodule

// File: tb/tb_uartrx_frame_chk.sv
// Directed bench: three frame checker instances (1 stop, 2 stops, 2-bit error counter).
module tb_uartrx_frame_chk;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       frame_start [3];
  logic       bit_strobe  [3];
  logic       rx_bit      [3];
  logic [1:0] parity_mode [3];
  logic       fc_clear    [3];
  logic [7:0] rx_data     [3];
  logic       frame_done  [3];
  logic       parity_err  [3];
  logic       framing_err [3];
  logic       busy        [3];
  logic [7:0] ec0, ec1;
  logic [1:0] ec2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uartrx_frame_chk #(.DATA_BITS(8), .STOP_BITS(1), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .n_rst(n_rst), .frame_start(frame_start[0]), .bit_strobe(bit_strobe[0]),
    .rx_bit(rx_bit[0]), .parity_mode(parity_mode[0]), .fc_clear(fc_clear[0]),
    .rx_data(rx_data[0]), .frame_done(frame_done[0]), .parity_error(parity_err[0]),
    .framing_error(framing_err[0]), .busy(busy[0]), .err_count(ec0));

  uartrx_frame_chk #(.DATA_BITS(8), .STOP_BITS(2), .ERR_CNT_W(8)) dut_b (
    .clk(clk), .n_rst(n_rst), .frame_start(frame_start[1]), .bit_strobe(bit_strobe[1]),
    .rx_bit(rx_bit[1]), .parity_mode(parity_mode[1]), .fc_clear(fc_clear[1]),
    .rx_data(rx_data[1]), .frame_done(frame_done[1]), .parity_error(parity_err[1]),
    .framing_error(framing_err[1]), .busy(busy[1]), .err_count(ec1));

  uartrx_frame_chk #(.DATA_BITS(8), .STOP_BITS(1), .ERR_CNT_W(2)) dut_c (
    .clk(clk), .n_rst(n_rst), .frame_start(frame_start[2]), .bit_strobe(bit_strobe[2]),
    .rx_bit(rx_bit[2]), .parity_mode(parity_mode[2]), .fc_clear(fc_clear[2]),
    .rx_data(rx_data[2]), .frame_done(frame_done[2]), .parity_error(parity_err[2]),
    .framing_error(framing_err[2]), .busy(busy[2]), .err_count(ec2));

  function automatic logic [7:0] ecnt(int i);
    case (i)
      0:       return ec0;
      1:       return ec1;
      default: return {6'b0, ec2};
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(int i, logic [1:0] mode);
    frame_start[i] = 1'b1;
    parity_mode[i] = mode;
    tick();
    frame_start[i] = 1'b0;
  endtask

  task automatic strb(int i, logic b);
    bit_strobe[i] = 1'b1;
    rx_bit[i]     = b;
    tick();
    bit_strobe[i] = 1'b0;
  endtask

  // Whole frame with one idle cycle between strobes; checks the frame_done pulse shape.
  task automatic send_frame(int i, logic [1:0] mode, logic [7:0] d, logic pb,
                            logic [1:0] stops, int nstop, logic clr_last);
    start(i, mode);
    tick();
    for (int k = 0; k < 8; k++) begin
      strb(i, d[k]);
      tick();
    end
    if (mode == 2'b01 || mode == 2'b10) begin
      strb(i, pb);
      tick();
    end
    for (int s = 0; s < nstop; s++) begin
      if (s == nstop - 1) begin
        check("busy_in_frame", busy[i], 1'b1);
        fc_clear[i] = clr_last;
        strb(i, stops[s]);
        fc_clear[i] = 1'b0;
      end else begin
        strb(i, stops[s]);
        tick();
      end
    end
    check("frame_done_pulse", frame_done[i], 1'b1);
    tick();
    check("frame_done_end", frame_done[i], 1'b0);
    check("busy_after_done", busy[i], 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      frame_start[i] = 1'b0;
      bit_strobe[i]  = 1'b0;
      rx_bit[i]      = 1'b1;
      parity_mode[i] = 2'b00;
      fc_clear[i]    = 1'b0;
    end
    #12;
    check("rst_rx_data", rx_data[0], 8'h00);
    check("rst_frame_done", frame_done[0], 1'b0);
    check("rst_flags", {parity_err[0], framing_err[0]}, 2'b00);
    check("rst_busy", busy[0], 1'b0);
    check("rst_err_count", ecnt(0), 8'd0);
    n_rst = 1'b1;
    tick();

    // 1: plain 8N1
    send_frame(0, 2'b00, 8'hA5, 1'b0, 2'b01, 1, 1'b0);
    check("t1_rx_data", rx_data[0], 8'hA5);
    check("t1_flags", {parity_err[0], framing_err[0]}, 2'b00);
    check("t1_err_count", ecnt(0), 8'd0);

    // 2: even parity
    send_frame(0, 2'b10, 8'hA5, 1'b0, 2'b01, 1, 1'b0);
    check("t2_par_ok", parity_err[0], 1'b0);
    check("t2_err0", ecnt(0), 8'd0);
    send_frame(0, 2'b10, 8'hA5, 1'b1, 2'b01, 1, 1'b0);
    check("t2_par_bad", parity_err[0], 1'b1);
    check("t2_err1", ecnt(0), 8'd1);
    send_frame(0, 2'b10, 8'hC3, 1'b0, 2'b01, 1, 1'b0);
    check("t2_par_clr", parity_err[0], 1'b0);
    check("t2_err_hold", ecnt(0), 8'd1);
    check("t2_rx_data", rx_data[0], 8'hC3);

    // 3: two stop bits, odd parity
    send_frame(1, 2'b01, 8'h3C, 1'b1, 2'b10 ^ 2'b11, 2, 1'b0);
    check("t3_framing", framing_err[1], 1'b1);
    check("t3_par", parity_err[1], 1'b0);
    check("t3_err", ecnt(1), 8'd1);
    check("t3_rx_data", rx_data[1], 8'h3C);
    send_frame(1, 2'b01, 8'h3C, 1'b1, 2'b11, 2, 1'b0);
    check("t3_good_flags", {parity_err[1], framing_err[1]}, 2'b00);
    check("t3_err_hold", ecnt(1), 8'd1);

    // 4: 2-bit counter saturation and clear on the DONE edge
    for (int f = 0; f < 6; f++) begin
      send_frame(2, 2'b00, 8'h0F, 1'b0, 2'b00, 1, 1'b0);
      check("t4_framing", framing_err[2], 1'b1);
      check("t4_err_sat", ecnt(2), (f < 3) ? 8'(f + 1) : 8'd3);
    end
    send_frame(2, 2'b00, 8'h81, 1'b0, 2'b00, 1, 1'b1);
    check("t4_clr_err", ecnt(2), 8'd0);
    check("t4_clr_framing", framing_err[2], 1'b0);
    check("t4_clr_rx_data", rx_data[2], 8'h81);

    // 5: protocol corners
    strb(0, 1'b0);
    tick();
    check("t5_idle_strobe", busy[0], 1'b0);
    frame_start[0] = 1'b1;
    bit_strobe[0]  = 1'b1;
    rx_bit[0]      = 1'b1;
    parity_mode[0] = 2'b00;
    tick();
    frame_start[0] = 1'b0;
    bit_strobe[0]  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      strb(0, (8'h3C >> k) & 8'h01);
      if (k == 2) frame_start[0] = 1'b1;
      if (k == 4) parity_mode[0] = 2'b10;
      tick();
      frame_start[0] = 1'b0;
    end
    strb(0, 1'b1);
    check("t5_done", frame_done[0], 1'b1);
    check("t5_rx_data", rx_data[0], 8'h3C);
    check("t5_flags", {parity_err[0], framing_err[0]}, 2'b00);
    parity_mode[0] = 2'b00;
    tick();

    // 6: reset mid-frame
    start(0, 2'b00);
    for (int k = 0; k < 4; k++) begin
      strb(0, 1'b1);
      tick();
    end
    n_rst = 1'b0;
    #1;
    check("t6_rx_data", rx_data[0], 8'h00);
    check("t6_busy", busy[0], 1'b0);
    check("t6_err", ecnt(0), 8'd0);
    check("t6_done", frame_done[0], 1'b0);
    tick();
    n_rst = 1'b1;
    tick();
    check("t6_no_done", frame_done[0], 1'b0);
    send_frame(0, 2'b00, 8'h5A, 1'b0, 2'b01, 1, 1'b0);
    check("t6_rx_data_new", rx_data[0], 8'h5A);
    check("t6_flags_new", {parity_err[0], framing_err[0]}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
